ysyx_ifu: RTL
=============

# ysyx_ifu

Instruction fetch unit for the ysyx multi-cycle RV32 core. Owns the program counter, issues one word read per instruction to instruction memory over a valid/ready request/response channel, and presents the fetched `inst`/`pc` pair to the decode stage. It holds that pair stable until the core commits the instruction and returns the next PC. It is the producing end of the decode unit's `inst`/`pc` interface.

## Interface
Parameters:
- `RESET_PC`, default `32'h8000_0000`: PC loaded on reset.
- `NOP_INST`, default `32'h0000_0013`: value driven on `inst` while no fetched instruction is held.

Ports (reset is asynchronous, active-high):
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous reset.
- `imem_req_valid`  out  1  fetch request valid.
- `imem_req_ready`  in  1  memory accepts the request.
- `imem_addr`  out  32  fetch address; equals `pc`.
- `imem_rsp_valid`  in  1  read data valid.
- `imem_rsp_ready`  out  1  IFU accepts the response.
- `imem_rsp_data`  in  32  instruction word.
- `imem_rsp_err`  in  1  access fault; qualified by `imem_rsp_valid`.
- `out_valid`  out  1  `inst`/`pc` valid toward decode.
- `out_ready`  in  1  decode/execute accepts the instruction.
- `inst`  out  32  held instruction.
- `pc`  out  32  PC of the held instruction.
- `commit_valid`  in  1  current instruction retired.
- `commit_npc`  in  32  next PC: sequential, branch target, or jump target.
- `fetch_err`  out  1  sticky fault flag.
- `fetch_cnt`  out  32  count of instructions handed to decode.

## Operation
- FSM states: `REQ`, `RSP`, `OUT`, `EXEC`, `ERR`. The state is registered. All control outputs are decoded from the state only, with no input-to-output combinational path except as stated below.
- `REQ`: `imem_req_valid=1`.
  - On `imem_req_ready` -> `RSP`.
- `RSP`: `imem_rsp_ready=1`.
  - On `imem_rsp_valid && !imem_rsp_err`: latch `imem_rsp_data` into `inst`, then -> `OUT`.
  - On `imem_rsp_valid && imem_rsp_err` -> `ERR`.
- `OUT`: `out_valid=1`.
  - On `out_ready`: increment `fetch_cnt` (wraps at 2^32), then -> `EXEC`.
- `EXEC`: `inst`/`pc` are held stable, because decode is combinational over them.
  - On `commit_valid`: `pc <= commit_npc` and `inst <= NOP_INST`.
  - If `commit_npc[1:0]==0`, -> `REQ`; otherwise -> `ERR`.
- `ERR`: terminal until reset.
  - `fetch_err=1`; all valid/ready outputs are 0.
  - `pc` keeps the faulting fetch address, or the misaligned `commit_npc`.
- `commit_valid` in any state other than `EXEC` is ignored.
- A response arriving outside `RSP` is not consumed, because `imem_rsp_ready=0`.
- `imem_addr` is always equal to `pc`.

## Timing
- Reset values: state=`REQ`, `pc=RESET_PC`, `inst=NOP_INST`, `fetch_cnt=0`, `fetch_err=0`.
- Output levels while `rst=1`: `imem_req_valid=0`, `imem_rsp_ready=0`, `out_valid=0`.
  - `imem_req_valid` is gated by `!rst` combinationally.
  - The first request is asserted in the first cycle after `rst` falls.
- Reset asserted mid-operation, in any state: all registers return to their reset values immediately (asynchronously). Any in-flight request or response is abandoned.
- Minimum latency: 4 cycles per instruction with zero-wait memory and decode.
  - Cycle 0: `REQ` accepted.
  - Cycle 1: `RSP` consumed.
  - Cycle 2: `OUT` handshake.
  - Cycle 3: `EXEC` commit.
  - Cycle 4: next `REQ`.
- `inst` changes only on the `RSP` latch and on the `EXEC` commit.
- `pc` changes only on the `EXEC` commit and on reset.
- Handshake rule: while `imem_req_valid` or `out_valid` is high, `imem_addr`, `inst` and `pc` must not change until the handshake completes.
- `fetch_cnt` updates in the cycle after the `out_valid && out_ready` edge.

## Test plan
- Reset/first fetch:
  - Stimulus: hold `rst` 3 cycles, then release; memory ready and responding at zero wait with `32'h00100093`.
  - Required: cycle 0 after reset has `imem_req_valid=1`, `imem_addr=32'h8000_0000`; cycle 2 has `out_valid=1`, `inst=32'h00100093`, `pc=32'h8000_0000`.
- Sequential stream:
  - Stimulus: 5 instructions, commit with `npc=pc+4`.
  - Required: addresses `8000_0000..8000_0010`; `fetch_cnt=5`; exactly 4 cycles per instruction.
- Backpressure:
  - Stimulus: `imem_req_ready` low for 3 cycles, `imem_rsp_valid` delayed 2 cycles, `out_ready` low for 4 cycles.
  - Required: `imem_addr`, `inst` and `pc` remain stable throughout; no duplicate request; `fetch_cnt` increments once.
- Jump and misalignment:
  - Stimulus: commit with `commit_npc=32'h8000_0100`.
  - Required: next `imem_addr=32'h8000_0100`.
  - Stimulus: commit with `commit_npc=32'h8000_0102`.
  - Required: `fetch_err=1`, no further requests, `pc=32'h8000_0102`.
- Access fault:
  - Stimulus: `imem_rsp_err=1` together with `imem_rsp_valid`.
  - Required: `fetch_err=1`, `out_valid` never asserted, `fetch_cnt` unchanged.
- Reset mid-operation and stray commit:
  - Stimulus: assert `rst` during `EXEC`.
  - Required: `pc=RESET_PC`, `inst=32'h0000_0013`, `fetch_err=0` with no clock edge needed.
  - Stimulus: pulse `commit_valid` while in `RSP`.
  - Required: `pc` unchanged.

Source files
------------

// File: rtl/ysyx_ifu_if.sv
// Fetch-unit bundle: instruction-memory request/response, decode handoff,
// commit feedback and status. The IFU drives it through the master modport.
interface ysyx_ifu_if;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_addr;
  logic        imem_rsp_valid;
  logic        imem_rsp_ready;
  logic [31:0] imem_rsp_data;
  logic        imem_rsp_err;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] inst;
  logic [31:0] pc;
  logic        commit_valid;
  logic [31:0] commit_npc;
  logic        fetch_err;
  logic [31:0] fetch_cnt;

  modport master (
    output imem_req_valid, input  imem_req_ready, output imem_addr,
    input  imem_rsp_valid, output imem_rsp_ready, input  imem_rsp_data,
    input  imem_rsp_err,
    output out_valid,      input  out_ready,      output inst, output pc,
    input  commit_valid,   input  commit_npc,
    output fetch_err,      output fetch_cnt
  );

  modport slave (
    input  imem_req_valid, output imem_req_ready, input  imem_addr,
    output imem_rsp_valid, input  imem_rsp_ready, output imem_rsp_data,
    output imem_rsp_err,
    input  out_valid,      output out_ready,      input  inst, input pc,
    output commit_valid,   output commit_npc,
    input  fetch_err,      input  fetch_cnt
  );
endinterface

// File: rtl/ysyx_ifu.sv
// Multi-cycle instruction fetch unit: owns the PC, fetches one word per
// instruction and holds inst/pc for decode until the core commits.
module ysyx_ifu #(
  parameter logic [31:0] RESET_PC = 32'h8000_0000,
  parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
  input  logic       clk,
  input  logic       rst,
  ysyx_ifu_if.master bus
);

  typedef enum logic [2:0] {REQ, RSP, OUT, EXEC, ERR} state_e;

  state_e      state;
  state_e      state_nxt;
  logic [31:0] pc_q;
  logic [31:0] inst_q;
  logic [31:0] cnt_q;
  logic        rsp_ok;
  logic        out_fire;
  logic        commit_fire;

  assign rsp_ok      = (state == RSP) && bus.imem_rsp_valid && !bus.imem_rsp_err;
  assign out_fire    = (state == OUT) && bus.out_ready;
  assign commit_fire = (state == EXEC) && bus.commit_valid;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= REQ;
    else     state <= state_nxt;
  end

  // ERR is terminal; a misaligned next PC is caught at commit rather than fetched.
  always_comb begin
    state_nxt = state;
    case (state)
      REQ:     if (bus.imem_req_ready) state_nxt = RSP;
      RSP:     if (bus.imem_rsp_valid) state_nxt = bus.imem_rsp_err ? ERR : OUT;
      OUT:     if (bus.out_ready)      state_nxt = EXEC;
      EXEC:    if (bus.commit_valid)
                 state_nxt = (bus.commit_npc[1:0] == 2'b00) ? REQ : ERR;
      ERR:     state_nxt = ERR;
      default: state_nxt = ERR;
    endcase
  end

  // Request valid is masked by rst so nothing is offered while reset is held.
  always_comb begin
    bus.imem_req_valid = 1'b0;
    bus.imem_rsp_ready = 1'b0;
    bus.out_valid      = 1'b0;
    bus.fetch_err      = 1'b0;
    case (state)
      REQ:     bus.imem_req_valid = !rst;
      RSP:     bus.imem_rsp_ready = 1'b1;
      OUT:     bus.out_valid      = 1'b1;
      ERR:     bus.fetch_err      = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q   <= RESET_PC;
      inst_q <= NOP_INST;
      cnt_q  <= 32'd0;
    end else begin
      if (rsp_ok) inst_q <= bus.imem_rsp_data;
      if (out_fire) cnt_q <= cnt_q + 32'd1;
      if (commit_fire) begin
        pc_q   <= bus.commit_npc;
        inst_q <= NOP_INST;
      end
    end
  end

  assign bus.imem_addr = pc_q;
  assign bus.pc        = pc_q;
  assign bus.inst      = inst_q;
  assign bus.fetch_cnt = cnt_q;

endmodule
